lock_controller: RTL and testbench



---
 rtl/lock_pkg.sv | 15 +
 rtl/lock_controller_if.sv | 22 ++
 rtl/key_edge.sv | 27 ++
 rtl/lock_controller.sv | 177 +++++++++++++++++
 tb/tb_lock_controller.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
// Shared key codes, state encoding and widths for the keypad lock.
package lock_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic [NIBBLE_W-1:0] KEY_STAR = 4'd10;
  localparam logic [NIBBLE_W-1:0] KEY_HASH = 4'd11;

  typedef enum logic [2:0] {
    StLocked  = 3'b001,
    StOpen    = 3'b010,
    StLockout = 3'b100
  } lock_state_e;

endpackage

// File: rtl/lock_controller_if.sv
// Keypad-side inputs and actuator/status outputs of the lock controller.
interface lock_controller_if;
  import lock_pkg::*;

  logic [NIBBLE_W-1:0] code;
  logic                valid;
  logic                unlock;
  logic                alarm;
  logic                ok;
  logic                err;
  logic [3:0]          digit_cnt;

  modport master (
    output code, valid,
    input  unlock, alarm, ok, err, digit_cnt
  );

  modport slave (
    input  code, valid,
    output unlock, alarm, ok, err, digit_cnt
  );
endinterface

// File: rtl/key_edge.sv
// Converts the scanner's Valid level into a single-cycle key strobe.
module key_edge
  import lock_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic [NIBBLE_W-1:0] i_code,
  output logic                o_stb,
  output logic [NIBBLE_W-1:0] o_code
);

  logic r_valid_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= i_valid;
    end
  end

  // A key already held at reset release still yields one strobe.
  assign o_stb  = i_valid & ~r_valid_q;
  assign o_code = i_code;

endmodule

// File: rtl/lock_controller.sv
// Passcode entry, compare, code change, auto-relock and failure lockout.
module lock_controller
  import lock_pkg::*;
#(
  parameter int unsigned          CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] RESET_CODE    = 16'h1234,
  parameter int unsigned          OPEN_CYCLES    = 5000,
  parameter int unsigned          LOCKOUT_CYCLES = 20000,
  parameter int unsigned          MAX_FAIL       = 3,
  parameter int unsigned          TIMER_W        = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  lock_controller_if.slave   io_bus
);

  localparam int unsigned BUF_W  = NIBBLE_W * CODE_LEN;
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [3:0]         CNT_FULL  = 4'(CODE_LEN);
  localparam logic [3:0]         CNT_OVF   = 4'(CODE_LEN + 1);
  localparam logic [TIMER_W-1:0] OPEN_LD   = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LD   = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FAIL_W-1:0]  FAIL_LIM  = FAIL_W'(MAX_FAIL);

  lock_state_e         r_state, w_state;
  logic [BUF_W-1:0]    r_code, w_code;
  logic [BUF_W-1:0]    r_buf, w_buf;
  logic [3:0]          r_cnt, w_cnt;
  logic [FAIL_W-1:0]   r_fail, w_fail;
  logic [TIMER_W-1:0]  r_timer, w_timer;
  logic                r_ok, w_ok;
  logic                r_err, w_err;

  logic                w_stb;
  logic [NIBBLE_W-1:0] w_key;
  logic [BUF_W-1:0]    w_ent_buf;
  logic [3:0]          w_ent_cnt;
  logic                w_is_hash;
  logic                w_match;
  logic [FAIL_W-1:0]   w_fail_inc;

  key_edge u_key_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (io_bus.valid),
    .i_code  (io_bus.code),
    .o_stb   (w_stb),
    .o_code  (w_key)
  );

  // Effect of a digit or '*' on the entry buffer; '#' and 12-15 leave it alone.
  always_comb begin
    w_ent_buf = r_buf;
    w_ent_cnt = r_cnt;
    if (w_key < 4'd10) begin
      if (r_cnt < CNT_FULL) begin
        w_ent_buf = (r_buf << NIBBLE_W) | BUF_W'(w_key);
        w_ent_cnt = r_cnt + 4'd1;
      end else if (r_cnt == CNT_FULL) begin
        w_ent_cnt = CNT_OVF;
      end
    end else if (w_key == KEY_STAR) begin
      w_ent_buf = '0;
      w_ent_cnt = '0;
    end
  end

  assign w_is_hash  = w_stb && (w_key == KEY_HASH);
  assign w_match    = (r_cnt == CNT_FULL) && (r_buf == r_code);
  assign w_fail_inc = r_fail + FAIL_W'(1);

  always_comb begin
    w_state = r_state;
    w_code  = r_code;
    w_buf   = r_buf;
    w_cnt   = r_cnt;
    w_fail  = r_fail;
    w_timer = r_timer;
    w_ok    = 1'b0;
    w_err   = 1'b0;
    unique case (r_state)
      StLocked: begin
        if (w_is_hash) begin
          w_buf = '0;
          w_cnt = '0;
          if (w_match) begin
            w_ok    = 1'b1;
            w_fail  = '0;
            w_state = StOpen;
            w_timer = OPEN_LD;
          end else begin
            w_err  = 1'b1;
            w_fail = w_fail_inc;
            if (w_fail_inc >= FAIL_LIM) begin
              w_fail  = '0;
              w_state = StLockout;
              w_timer = LOCK_LD;
            end
          end
        end else if (w_stb) begin
          w_buf = w_ent_buf;
          w_cnt = w_ent_cnt;
        end
      end
      StOpen: begin
        // Expiry takes priority; a strobe in the same cycle is dropped.
        if (r_timer == '0) begin
          w_state = StLocked;
        end else begin
          w_timer = r_timer - TIMER_W'(1);
          if (w_is_hash) begin
            w_buf = '0;
            w_cnt = '0;
            if (r_cnt == '0) begin
              w_state = StLocked;
              w_timer = '0;
            end else if (r_cnt == CNT_FULL) begin
              w_code  = r_buf;
              w_ok    = 1'b1;
              w_timer = OPEN_LD;
            end else begin
              w_err = 1'b1;
            end
          end else if (w_stb) begin
            w_buf = w_ent_buf;
            w_cnt = w_ent_cnt;
          end
        end
      end
      StLockout: begin
        w_buf = '0;
        w_cnt = '0;
        if (r_timer == '0) begin
          w_state = StLocked;
        end else begin
          w_timer = r_timer - TIMER_W'(1);
        end
      end
      default: begin
        w_state = StLocked;
        w_buf   = '0;
        w_cnt   = '0;
        w_timer = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StLocked;
      r_code  <= RESET_CODE;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_fail  <= '0;
      r_timer <= '0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_code  <= w_code;
      r_buf   <= w_buf;
      r_cnt   <= w_cnt;
      r_fail  <= w_fail;
      r_timer <= w_timer;
      r_ok    <= w_ok;
      r_err   <= w_err;
    end
  end

  assign io_bus.unlock    = (r_state == StOpen);
  assign io_bus.alarm     = (r_state == StLockout);
  assign io_bus.ok        = r_ok;
  assign io_bus.err       = r_err;
  assign io_bus.digit_cnt = r_cnt;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller with shortened open/lockout timers.
module tb_lock_controller;
  import lock_pkg::*;

  localparam int unsigned OPEN_C = 40;
  localparam int unsigned LOCK_C = 100;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic seen_ok;
  logic seen_err;

  lock_controller_if bus ();

  lock_controller #(
    .CODE_LEN       (4),
    .RESET_CODE     (16'h1234),
    .OPEN_CYCLES    (OPEN_C),
    .LOCKOUT_CYCLES (LOCK_C),
    .MAX_FAIL       (3),
    .TIMER_W        (16)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One press: strobe edge, capture the registered pulses, then an idle cycle.
  task automatic press(input logic [3:0] k);
    bus.code  = k;
    bus.valid = 1'b1;
    tick();
    seen_ok   = bus.ok;
    seen_err  = bus.err;
    bus.valid = 1'b0;
    tick();
  endtask

  task automatic enter4(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[4*i +: 4]);
  endtask

  task automatic try_code(input logic [15:0] c);
    enter4(c);
    press(KEY_HASH);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check_eq({tag, "_unlock"}, int'(bus.unlock), 0);
    check_eq({tag, "_alarm"}, int'(bus.alarm), 0);
    check_eq({tag, "_ok"}, int'(bus.ok), 0);
    check_eq({tag, "_err"}, int'(bus.err), 0);
    check_eq({tag, "_cnt"}, int'(bus.digit_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    seen_ok   = 1'b0;
    seen_err  = 1'b0;
    rst_n     = 1'b0;
    bus.code  = 4'd0;
    bus.valid = 1'b0;
    #12;
    check_eq("rst_unlock", int'(bus.unlock), 0);
    check_eq("rst_alarm", int'(bus.alarm), 0);
    check_eq("rst_ok", int'(bus.ok), 0);
    check_eq("rst_err", int'(bus.err), 0);
    check_eq("rst_cnt", int'(bus.digit_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Correct code opens; unlock lasts exactly OPEN_C clocks.
    enter4(16'h1234);
    check_eq("cnt_full", int'(bus.digit_cnt), 4);
    press(KEY_HASH);
    check_eq("open_ok", int'(seen_ok), 1);
    check_eq("open_err", int'(seen_err), 0);
    check_eq("open_unlock", int'(bus.unlock), 1);
    check_eq("open_cnt_clr", int'(bus.digit_cnt), 0);
    ticks(OPEN_C - 2);
    check_eq("open_last", int'(bus.unlock), 1);
    tick();
    check_eq("open_expired", int'(bus.unlock), 0);

    // Three wrong codes -> lockout, presses ignored, then recovery.
    for (int i = 0; i < 3; i++) begin
      try_code(16'h1235);
      check_eq("bad_err", int'(seen_err), 1);
      check_eq("bad_ok", int'(seen_ok), 0);
      check_eq("bad_alarm", int'(bus.alarm), (i == 2) ? 1 : 0);
    end
    press(4'd5);
    check_eq("lockout_cnt", int'(bus.digit_cnt), 0);
    ticks(LOCK_C - 4);
    check_eq("lockout_last", int'(bus.alarm), 1);
    tick();
    check_eq("lockout_over", int'(bus.alarm), 0);
    try_code(16'h1234);
    check_eq("after_lock_ok", int'(seen_ok), 1);
    check_eq("after_lock_unlock", int'(bus.unlock), 1);

    // Code change, '#' alone relocks, old code rejected, new code accepted.
    try_code(16'h9876);
    check_eq("chg_ok", int'(seen_ok), 1);
    check_eq("chg_unlock", int'(bus.unlock), 1);
    press(KEY_HASH);
    check_eq("relock_ok", int'(seen_ok), 0);
    check_eq("relock_err", int'(seen_err), 0);
    check_eq("relock_unlock", int'(bus.unlock), 0);
    try_code(16'h1234);
    check_eq("old_err", int'(seen_err), 1);
    check_eq("old_unlock", int'(bus.unlock), 0);
    try_code(16'h9876);
    check_eq("new_ok", int'(seen_ok), 1);
    check_eq("new_unlock", int'(bus.unlock), 1);
    press(KEY_HASH);
    check_eq("relock2", int'(bus.unlock), 0);

    // Held key gives one digit; overflow rejected.
    bus.code  = 4'd5;
    bus.valid = 1'b1;
    ticks(50);
    check_eq("hold_cnt", int'(bus.digit_cnt), 1);
    bus.valid = 1'b0;
    tick();
    press(KEY_STAR);
    check_eq("star_cnt", int'(bus.digit_cnt), 0);
    enter4(16'h1234);
    press(4'd5);
    check_eq("ovf_cnt", int'(bus.digit_cnt), 5);
    press(4'd14);
    check_eq("ign_cnt", int'(bus.digit_cnt), 5);
    press(KEY_HASH);
    check_eq("ovf_err", int'(seen_err), 1);
    check_eq("ovf_cnt_clr", int'(bus.digit_cnt), 0);

    // '*' mid-entry, then a '#' strobe on the expiry cycle is dropped.
    press(4'd1);
    press(4'd2);
    press(KEY_STAR);
    try_code(16'h9876);
    check_eq("star_open", int'(bus.unlock), 1);
    enter4(16'h1234);
    ticks(OPEN_C - 10);
    press(KEY_HASH);
    check_eq("exp_hash_ok", int'(seen_ok), 0);
    check_eq("exp_hash_err", int'(seen_err), 0);
    check_eq("exp_hash_unlock", int'(bus.unlock), 0);
    press(KEY_STAR);
    try_code(16'h9876);
    check_eq("code_kept", int'(bus.unlock), 1);

    // Reset while open after a change, and mid-entry, restores RESET_CODE.
    try_code(16'h5555);
    check_eq("chg2_ok", int'(seen_ok), 1);
    async_reset("rst_open");
    press(4'd1);
    press(4'd2);
    check_eq("mid_cnt", int'(bus.digit_cnt), 2);
    async_reset("rst_mid");
    try_code(16'h1234);
    check_eq("rst_code_ok", int'(seen_ok), 1);
    check_eq("rst_code_unlock", int'(bus.unlock), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
